uart_tx_dev: RTL and testbench
==============================

UART_TX_DEV -- requirements
Module: uart_tx_dev

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-002 Parameter DEFAULT_DIV, default 16, SHALL set the reset value of the baud divisor register.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Addr  input  32  SHALL be the CPU data-bus byte address; only Addr[3:2] SHALL be decoded, and base-range decode is external.
REQ-006 WE  input  1  SHALL be the write strobe, already qualified by the external range decode and by any-byteen-set.
REQ-007 Din  input  32  SHALL be the CPU write data.
REQ-008 Dout  output  32  SHALL be the read data for Addr[3:2], combinational from current register state.
REQ-009 IRQ  output  1  SHALL be a level interrupt request to the CPU interrupt input.
REQ-010 txd  output  1  SHALL be the serial line, idle high.

Function
REQ-011 Register map by Addr[3:2]: 0 DATA (write-only, reads 0), 1 STATUS, 2 CTRL, 3 DIV.
REQ-012 STATUS read SHALL be {zeros, ovf[8], irq_en[7], busy[6], full[5], empty[4], count[3:0]}; count SHALL saturate at FIFO_DEPTH.
REQ-013 CTRL: bit0 irq_en, reset 0; other bits read 0, writes ignored.
REQ-014 DIV: bits[15:0] = bit period in clk cycles, reset DEFAULT_DIV; value 0 SHALL be treated as 1; bits[31:16] read 0.
REQ-015 Write to DATA SHALL push Din[7:0] into the FIFO when not full at the start of that cycle; a pop in the same cycle SHALL NOT make room.
REQ-016 Write to DATA when full SHALL discard the byte and set sticky ovf; any write to STATUS SHALL clear ovf.
REQ-017 TX FSM states IDLE, START, DATA, STOP; IDLE SHALL pop the FIFO head and enter START on the first cycle the FIFO is non-empty.
REQ-018 Frame 8N1: START drives 0, DATA drives bits 0..7 LSB first, STOP drives 1, each for exactly one bit period.
REQ-019 Pop-to-txd-low latency SHALL be 1 cycle (txd registered); full frame SHALL occupy 10 bit periods.
REQ-020 STOP end SHALL go to START with the next byte in the same cycle if the FIFO is non-empty, else IDLE; back-to-back frames SHALL have no idle gap.
REQ-021 busy SHALL be 1 in START, DATA and STOP.
REQ-022 The bit-period counter SHALL reload from DIV at each bit boundary; a DIV write mid-bit SHALL take effect at the next boundary.
REQ-023 IRQ SHALL equal irq_en AND empty AND NOT busy (transmitter drained); it SHALL deassert in the cycle after a DATA push or irq_en clear.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; simultaneous push and pop with count between 1 and FIFO_DEPTH-1 SHALL leave count unchanged.

Reset
REQ-025 During reset: txd 1, IRQ 0, FSM IDLE, FIFO empty (count 0), ovf 0, irq_en 0, DIV = DEFAULT_DIV, Dout per these values.
REQ-026 Reset asserted mid-frame SHALL abort the frame immediately, driving txd 1 without waiting for a clock edge, and discard all FIFO contents.

Verification
REQ-027 DIV=4, write DATA 0x55 -> txd low 1 cycle after push, then 1,0,1,0,1,0,1,0 then 1, each held 4 cycles; 40 cycles total.
REQ-028 DIV=2, write 0x01,0x02,0x03,0x04,0x05 back-to-back while idle -> first pops at once, next four fill FIFO, none dropped, ovf 0; one more write -> dropped, STATUS ovf=1, full=1.
REQ-029 irq_en=1, write one byte at DIV=3 -> IRQ 0 from next cycle, returns 1 exactly when STOP of that frame ends; irq_en=0 -> IRQ stays 0.
REQ-030 Write DIV=0 then DATA 0xFF -> each bit lasts 1 cycle; STATUS read mid-frame shows busy=1, empty=1.
REQ-031 Assert reset during DATA bit 3 with 2 bytes queued -> txd 1 asynchronously, STATUS reads 0x10, DIV reads DEFAULT_DIV, IRQ 0.
REQ-032 Write DIV=8 during bit 2 of a DIV=4 frame -> bit 2 ends after 4 cycles, bits 3..7 and STOP last 8 cycles.

Source files
------------

// File: rtl/uart_tx_dev_if.sv
// CPU-side bus of the UART transmitter: register access plus the interrupt line.
// The CPU drives the master modport; the peripheral uses the slave modport.
interface uart_tx_dev_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, output WE, output Din, input Dout, input IRQ);
    modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO, a programmable baud divisor
// and a level interrupt that fires once the transmitter has fully drained.
module uart_tx_dev #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 16
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_dev_if.slave bus,
    output logic         txd
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [15:0]      DIV_RESET = 16'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } txState_e;

    // Register decode
    logic [1:0] regSel;
    logic       wrData;
    logic       wrStatus;
    logic       wrCtrl;
    logic       wrDiv;

    assign regSel   = bus.Addr[3:2];
    assign wrData   = bus.WE && (regSel == 2'd0);
    assign wrStatus = bus.WE && (regSel == 2'd1);
    assign wrCtrl   = bus.WE && (regSel == 2'd2);
    assign wrDiv    = bus.WE && (regSel == 2'd3);

    logic unusedBits;
    assign unusedBits = ^{bus.Addr[31:4], bus.Addr[1:0], bus.Din[31:16]};

    // Control and status registers
    logic [15:0] div_q, div_d;
    logic        irqEn_q, irqEn_d;
    logic        ovf_q, ovf_d;

    // FIFO storage and bookkeeping
    logic [7:0]       fifoMem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Transmitter state
    txState_e    state_q, state_d;
    logic [15:0] baudCnt_q, baudCnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic [15:0] divEff;
    logic        bitEnd;
    logic        busy;

    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_C);
    assign push   = wrData && !full;
    assign divEff = (div_q == 16'd0) ? 16'd1 : div_q;
    assign bitEnd = (baudCnt_q == 16'd1);
    assign busy   = (state_q != IDLE);
    assign txd    = txd_q;

    always_comb begin
        div_d   = div_q;
        irqEn_d = irqEn_q;
        ovf_d   = ovf_q;
        if (wrDiv) begin
            div_d = bus.Din[15:0];
        end
        if (wrCtrl) begin
            irqEn_d = bus.Din[0];
        end
        if (wrStatus) begin
            ovf_d = 1'b0;
        end else if (wrData && full) begin
            ovf_d = 1'b1;
        end
    end

    // Fullness is judged before this cycle's pop, so a same-cycle pop never frees a slot.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= bus.Din[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= DIV_RESET;
            irqEn_q <= 1'b0;
            ovf_q   <= 1'b0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            div_q   <= div_d;
            irqEn_q <= irqEn_d;
            ovf_q   <= ovf_d;
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            baudCnt_q <= '0;
            bitIdx_q  <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baudCnt_q <= baudCnt_d;
            bitIdx_q  <= bitIdx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    // txd_d is the level for the next bit, so the line changes on the edge that ends a bit.
    always_comb begin
        state_d   = state_q;
        baudCnt_d = baudCnt_q;
        bitIdx_d  = bitIdx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;

        if (busy && !bitEnd) begin
            baudCnt_d = baudCnt_q - 16'd1;
        end

        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop       = 1'b1;
                    shift_d   = fifoMem_q[rdPtr_q];
                    baudCnt_d = divEff;
                    txd_d     = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    baudCnt_d = divEff;
                    txd_d     = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bitIdx_d  = 3'd0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    baudCnt_d = divEff;
                    if (bitIdx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        txd_d    = shift_q[0];
                        shift_d  = {1'b0, shift_q[7:1]};
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bitEnd) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        shift_d   = fifoMem_q[rdPtr_q];
                        baudCnt_d = divEff;
                        txd_d     = 1'b0;
                        state_d   = START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                txd_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // Read mux and interrupt
    logic [4:0]  countWide;
    logic [3:0]  statusCnt;
    logic [31:0] rdata;

    assign countWide = 5'(count_q);
    assign statusCnt = (countWide > 5'd15) ? 4'hF : countWide[3:0];

    always_comb begin
        rdata = 32'd0;
        case (regSel)
            2'd1:    rdata = {23'd0, ovf_q, irqEn_q, busy, full, empty, statusCnt};
            2'd2:    rdata = {31'd0, irqEn_q};
            2'd3:    rdata = {16'd0, div_q};
            default: rdata = 32'd0;
        endcase
    end

    assign bus.Dout = rdata;
    assign bus.IRQ  = irqEn_q && empty && !busy;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev: register access, frame timing,
// FIFO fill/overflow, interrupt behaviour, mid-frame divisor change and async reset.
module tb_uart_tx_dev;

    logic clk;
    logic reset;
    logic txd;
    int   checks;
    int   fails;
    bit   expWave[$];

    uart_tx_dev_if bus();

    uart_tx_dev #(
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .txd  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.Addr = addr;
        bus.Din  = data;
        bus.WE   = 1'b1;
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 32'h4;
        #1;
    endtask

    task automatic readReg(input string tag, input logic [31:0] addr, input logic [31:0] expected);
        bus.Addr = addr;
        #1;
        checkOutput(tag, bus.Dout, expected);
        bus.Addr = 32'h4;
    endtask

    task automatic addSeg(input bit level, input int len);
        for (int i = 0; i < len; i++) expWave.push_back(level);
    endtask

    task automatic addFrame(input logic [7:0] data, input int div);
        addSeg(1'b0, div);
        for (int i = 0; i < 8; i++) addSeg(data[i], div);
        addSeg(1'b1, div);
    endtask

    // Sample index 0 is the first cycle of the first start bit.
    task automatic checkWave(input string tag, input int startS, input int wrAt,
                             input logic [31:0] wrAddr, input logic [31:0] wrData,
                             input int statAt, input logic [31:0] statExp,
                             input logic irqAfter, input logic [31:0] postStatus);
        for (int s = startS; s < expWave.size(); s++) begin
            @(negedge clk);
            if (bus.WE) begin
                bus.WE   = 1'b0;
                bus.Addr = 32'h4;
                #1;
            end
            checkOutput($sformatf("%s txd[%0d]", tag, s), 32'(txd), 32'(expWave[s]));
            checkOutput($sformatf("%s irq[%0d]", tag, s), 32'(bus.IRQ), 32'd0);
            if (s == statAt) checkOutput($sformatf("%s midStatus", tag), bus.Dout, statExp);
            if (s == wrAt) begin
                bus.Addr = wrAddr;
                bus.Din  = wrData;
                bus.WE   = 1'b1;
            end
        end
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 32'h4;
        #1;
        checkOutput($sformatf("%s idleTxd", tag), 32'(txd), 32'd1);
        checkOutput($sformatf("%s irqAfter", tag), 32'(bus.IRQ), 32'(irqAfter));
        checkOutput($sformatf("%s postStatus", tag), bus.Dout, postStatus);
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        reset    = 1'b1;
        bus.Addr = 32'h4;
        bus.WE   = 1'b0;
        bus.Din  = 32'h0;

        repeat (3) @(negedge clk);
        #1;
        checkOutput("reset txd", 32'(txd), 32'd1);
        checkOutput("reset irq", 32'(bus.IRQ), 32'd0);
        readReg("reset status", 32'h4, 32'h10);
        readReg("reset ctrl", 32'h8, 32'h0);
        readReg("reset div", 32'hC, 32'd16);
        readReg("reset data", 32'h0, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // 0x55 at DIV=4
        applyStimulus(32'hC, 32'd4);
        readReg("div4", 32'hC, 32'd4);
        applyStimulus(32'h0, 32'h55);
        checkOutput("pop latency txd", 32'(txd), 32'd1);
        expWave.delete();
        addFrame(8'h55, 4);
        checkWave("f55", 0, -1, 32'h0, 32'h0, 10, 32'h50, 1'b0, 32'h10);

        // DIV=0 behaves as one cycle per bit
        applyStimulus(32'hC, 32'h0);
        readReg("div0", 32'hC, 32'h0);
        applyStimulus(32'h0, 32'hFF);
        expWave.delete();
        addFrame(8'hFF, 1);
        checkWave("fFF", 0, -1, 32'h0, 32'h0, 5, 32'h50, 1'b0, 32'h10);

        // Interrupt on drain
        applyStimulus(32'h8, 32'h1);
        readReg("ctrl en", 32'h8, 32'h1);
        checkOutput("irq idle en", 32'(bus.IRQ), 32'd1);
        applyStimulus(32'hC, 32'd3);
        checkOutput("irq div write", 32'(bus.IRQ), 32'd1);
        applyStimulus(32'h0, 32'hA3);
        checkOutput("irq after push", 32'(bus.IRQ), 32'd0);
        expWave.delete();
        addFrame(8'hA3, 3);
        checkWave("fA3", 0, -1, 32'h0, 32'h0, -1, 32'h0, 1'b1, 32'h90);
        applyStimulus(32'h8, 32'h0);
        checkOutput("irq disabled", 32'(bus.IRQ), 32'd0);
        applyStimulus(32'h0, 32'h3C);
        expWave.delete();
        addFrame(8'h3C, 3);
        checkWave("f3C", 0, -1, 32'h0, 32'h0, -1, 32'h0, 1'b0, 32'h10);

        // Burst of five at DIV=2, then an overflowing sixth
        applyStimulus(32'hC, 32'd2);
        @(negedge clk);
        bus.Addr = 32'h0;
        bus.Din  = 32'h01;
        bus.WE   = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            bus.Din = 32'(i);
        end
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 32'h4;
        #1;
        checkOutput("burst status full", bus.Dout, 32'h64);
        @(negedge clk);
        bus.Addr = 32'h0;
        bus.Din  = 32'h06;
        bus.WE   = 1'b1;
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 32'h4;
        #1;
        checkOutput("burst status ovf", bus.Dout, 32'h164);
        expWave.delete();
        for (int i = 1; i <= 5; i++) addFrame(8'(i), 2);
        checkWave("burst", 6, -1, 32'h0, 32'h0, -1, 32'h0, 1'b0, 32'h110);
        applyStimulus(32'h4, 32'h0);
        readReg("ovf cleared", 32'h4, 32'h10);

        // DIV 4 -> 8 written during data bit 2
        applyStimulus(32'hC, 32'd4);
        applyStimulus(32'h0, 32'h5A);
        expWave.delete();
        addSeg(1'b0, 4);
        for (int i = 0; i < 8; i++) addSeg(((8'h5A >> i) & 8'h1) != 0, (i < 3) ? 4 : 8);
        addSeg(1'b1, 8);
        checkWave("divChange", 0, 13, 32'hC, 32'd8, -1, 32'h0, 1'b0, 32'h10);
        readReg("div8", 32'hC, 32'd8);

        // Async reset in the middle of data bit 3 with two bytes queued
        applyStimulus(32'hC, 32'd4);
        @(negedge clk);
        bus.Addr = 32'h0;
        bus.Din  = 32'h00;
        bus.WE   = 1'b1;
        @(negedge clk);
        bus.Din  = 32'h11;
        @(negedge clk);
        bus.Din  = 32'h22;
        @(negedge clk);
        bus.WE   = 1'b0;
        bus.Addr = 32'h4;
        repeat (16) @(negedge clk);
        #1;
        checkOutput("bit3 txd", 32'(txd), 32'd0);
        checkOutput("bit3 status", bus.Dout, 32'h42);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async txd", 32'(txd), 32'd1);
        checkOutput("async irq", 32'(bus.IRQ), 32'd0);
        readReg("async status", 32'h4, 32'h10);
        readReg("async div", 32'hC, 32'd16);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("post reset txd[%0d]", i), 32'(txd), 32'd1);
        end
        readReg("post reset status", 32'h4, 32'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
